// File: rtl/core_ctrl_fsm_pkg.sv
// Shared types and constants for the execution controller: FSM states,
// trap cause indices, PC mux selects and the trap-vector helper.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_LSU = 3'd1,
    ST_WAIT_MC  = 3'd2,
    ST_JUMP_TGT = 3'd3,
    ST_HALTED   = 3'd4
  } ctrl_state_e;

  localparam logic [4:0] CAUSE_ECALL    = 5'd1;
  localparam logic [4:0] CAUSE_ILLEGAL  = 5'd2;
  localparam logic [4:0] CAUSE_IRQ_BASE = 5'd3;

  localparam logic [1:0] PC_BRANCH_JUMP = 2'd0;
  localparam logic [1:0] PC_EPC         = 2'd1;
  localparam logic [1:0] PC_EXCEPTION   = 2'd2;

  // Vector slot address for a cause; callers truncate to their address width.
  function automatic logic [31:0] trap_vector(input logic [31:0] base,
                                              input logic [31:0] stride,
                                              input logic [4:0]  cause);
    return base + stride * {27'd0, cause};
  endfunction

endpackage

// File: rtl/core_ctrl_fsm_if.sv
// Decoder/LSU/ALU-side flags into the controller and PC-mux/RF/CSR controls out.
interface core_ctrl_fsm_if #(
  parameter int ADDR_W  = 32,
  parameter int NUM_IRQ = 4,
  parameter int CNT_W   = 8
);
  logic               inst_valid_i;
  logic               jump_inst_i;
  logic               branch_inst_i;
  logic               comp_result_i;
  logic               ecall_inst_i;
  logic               ebreak_inst_i;
  logic               mret_inst_i;
  logic               illegal_inst_i;
  logic [NUM_IRQ-1:0] irq_i;
  logic [NUM_IRQ-1:0] irq_mask_i;
  logic               mie_i;
  logic               lsu_en_i;
  logic               lsu_done_i;
  logic               lsu_err_i;
  logic               mc_en_i;
  logic               mc_done_i;
  logic               resume_i;
  logic [CNT_W-1:0]   cycle_counter_o;
  logic               deassert_wen_n_o;
  logic               retire_o;
  logic [1:0]         pc_mux_sel_o;
  logic [ADDR_W-1:0]  exc_pc_o;
  logic               save_epc_o;
  logic [4:0]         cause_o;
  logic [NUM_IRQ-1:0] irq_ack_o;
  logic               target_valid_o;
  logic               halted_o;

  modport master (
    output inst_valid_i, jump_inst_i, branch_inst_i, comp_result_i,
           ecall_inst_i, ebreak_inst_i, mret_inst_i, illegal_inst_i,
           irq_i, irq_mask_i, mie_i, lsu_en_i, lsu_done_i, lsu_err_i,
           mc_en_i, mc_done_i, resume_i,
    input  cycle_counter_o, deassert_wen_n_o, retire_o, pc_mux_sel_o,
           exc_pc_o, save_epc_o, cause_o, irq_ack_o, target_valid_o, halted_o
  );

  modport slave (
    input  inst_valid_i, jump_inst_i, branch_inst_i, comp_result_i,
           ecall_inst_i, ebreak_inst_i, mret_inst_i, illegal_inst_i,
           irq_i, irq_mask_i, mie_i, lsu_en_i, lsu_done_i, lsu_err_i,
           mc_en_i, mc_done_i, resume_i,
    output cycle_counter_o, deassert_wen_n_o, retire_o, pc_mux_sel_o,
           exc_pc_o, save_epc_o, cause_o, irq_ack_o, target_valid_o, halted_o
  );
endinterface

// File: rtl/core_ctrl_fsm_irq_arbiter.sv
// Masked, globally-gated interrupt priority encoder; the lowest line index wins.
module ctrl_irq_arbiter #(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] mask_i,
  input  logic               en_i,
  output logic               valid_o,
  output logic [3:0]         idx_o,
  output logic [NUM_IRQ-1:0] onehot_o
);
  logic [NUM_IRQ-1:0] pending_s;

  // Isolate the lowest set bit, then encode it.
  always_comb begin
    pending_s = irq_i & mask_i & {NUM_IRQ{en_i}};
    onehot_o  = pending_s & (~pending_s + NUM_IRQ'(1));
    valid_o   = |pending_s;
    idx_o     = 4'd0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      idx_o = idx_o | (onehot_o[i] ? 4'(i) : 4'd0);
    end
  end
endmodule

// File: rtl/core_ctrl_fsm.sv
// Single-issue execution controller: sequences multi-cycle ops, takes vectored
// traps and halts on ebreak. Outputs decode combinationally from state and inputs.
module core_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          NUM_IRQ     = 4,
  parameter logic [31:0] VEC_BASE    = 32'd0,
  parameter logic [31:0] VEC_STRIDE  = 32'd4,
  parameter int          LSU_TIMEOUT = 16,
  parameter int          CNT_W       = 8
) (
  input logic             clk,
  input logic             rst,
  core_ctrl_fsm_if.slave  bus
);
  localparam logic [4:0]       CAUSE_LSU = CAUSE_IRQ_BASE + 5'(NUM_IRQ);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LSU_TIMEOUT - 1);
  localparam bit               TO_EN     = (LSU_TIMEOUT != 0);

  ctrl_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               irq_valid_s;
  logic [3:0]         irq_idx_s;
  logic [NUM_IRQ-1:0] irq_onehot_s;
  logic               trap_s;
  logic [4:0]         trap_cause_s;

  ctrl_irq_arbiter #(.NUM_IRQ(NUM_IRQ)) u_irq_arbiter (
    .irq_i    (bus.irq_i),
    .mask_i   (bus.irq_mask_i),
    .en_i     (bus.mie_i),
    .valid_o  (irq_valid_s),
    .idx_o    (irq_idx_s),
    .onehot_o (irq_onehot_s)
  );

  assign bus.cycle_counter_o = rst ? '0 : cnt_q;

  always_comb begin
    state_d              = state_q;
    trap_s               = 1'b0;
    trap_cause_s         = 5'd0;
    bus.deassert_wen_n_o = 1'b0;
    bus.retire_o         = 1'b0;
    bus.pc_mux_sel_o     = PC_BRANCH_JUMP;
    bus.exc_pc_o         = '0;
    bus.save_epc_o       = 1'b0;
    bus.cause_o          = 5'd0;
    bus.irq_ack_o        = '0;
    bus.target_valid_o   = 1'b0;
    bus.halted_o         = 1'b0;
    if (rst) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.inst_valid_i) begin
            if (irq_valid_s) begin
              trap_s        = 1'b1;
              trap_cause_s  = CAUSE_IRQ_BASE + {1'b0, irq_idx_s};
              bus.irq_ack_o = irq_onehot_s;
            end else if (bus.illegal_inst_i) begin
              trap_s       = 1'b1;
              trap_cause_s = CAUSE_ILLEGAL;
            end else if (bus.ecall_inst_i) begin
              trap_s       = 1'b1;
              trap_cause_s = CAUSE_ECALL;
            end else if (bus.ebreak_inst_i) begin
              state_d = ST_HALTED;
            end else if (bus.mret_inst_i) begin
              bus.pc_mux_sel_o   = PC_EPC;
              bus.target_valid_o = 1'b1;
              bus.retire_o       = 1'b1;
            end else if (bus.lsu_en_i) begin
              state_d = ST_WAIT_LSU;
            end else if (bus.mc_en_i) begin
              state_d = ST_WAIT_MC;
            end else if (bus.jump_inst_i) begin
              bus.deassert_wen_n_o = 1'b1;
              state_d              = ST_JUMP_TGT;
            end else if (bus.branch_inst_i) begin
              if (bus.comp_result_i) begin
                state_d = ST_JUMP_TGT;
              end else begin
                bus.retire_o = 1'b1;
              end
            end else begin
              bus.deassert_wen_n_o = 1'b1;
              bus.retire_o         = 1'b1;
            end
          end else begin
          end
        end
        ST_WAIT_LSU: begin
          // Bus error beats a same-cycle done: the loaded data is not trusted.
          if (bus.inst_valid_i) begin
            if (bus.lsu_err_i) begin
              trap_s       = 1'b1;
              trap_cause_s = CAUSE_LSU;
            end else if (bus.lsu_done_i) begin
              bus.deassert_wen_n_o = 1'b1;
              bus.retire_o         = 1'b1;
              state_d              = ST_IDLE;
            end else if (TO_EN && (cnt_q == TO_LAST)) begin
              trap_s       = 1'b1;
              trap_cause_s = CAUSE_LSU;
            end else begin
            end
          end else begin
          end
        end
        ST_WAIT_MC: begin
          if (bus.inst_valid_i && bus.mc_done_i) begin
            bus.deassert_wen_n_o = 1'b1;
            bus.retire_o         = 1'b1;
            state_d              = ST_IDLE;
          end else begin
          end
        end
        ST_JUMP_TGT: begin
          if (bus.inst_valid_i) begin
            bus.target_valid_o   = 1'b1;
            bus.retire_o         = 1'b1;
            bus.deassert_wen_n_o = bus.jump_inst_i;
            state_d              = ST_IDLE;
          end else begin
          end
        end
        ST_HALTED: begin
          bus.halted_o = 1'b1;
          if (bus.resume_i) begin
            bus.retire_o = 1'b1;
            state_d      = ST_IDLE;
          end else begin
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
      if (trap_s) begin
        bus.pc_mux_sel_o   = PC_EXCEPTION;
        bus.target_valid_o = 1'b1;
        bus.save_epc_o     = 1'b1;
        bus.cause_o        = trap_cause_s;
        bus.exc_pc_o       = ADDR_W'(trap_vector(VEC_BASE, VEC_STRIDE, trap_cause_s));
        state_d            = ST_IDLE;
      end else begin
      end
    end
    // Counter tracks dwell in the current non-IDLE state and saturates.
    if ((state_q == ST_IDLE) || (state_d == ST_IDLE)) begin
      cnt_d = '0;
    end else if ((bus.inst_valid_i || (state_q == ST_HALTED)) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and dwell counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
